// File: rtl/ring_lock_controller.sv
// ring_lock_controller
//   Closed-loop heater controller for a resonant ring modulator. After reset
//   it sweeps every heater code, locks to the code with the deepest
//   through-port notch, then holds (or tracks) that code and re-sweeps when
//   lock is lost.
//
//   Optional feature macro: RING_LOCK_TRACK_EN
//     defined   -> LOCKED runs +/-1 dither tracking around the locked code
//     undefined -> LOCKED holds the code and only monitors for loss of lock
//
//   Sample input protocol: mon_valid/mon_power is a valid-only stream (no
//   ready). A sample is consumed on any edge where mon_valid=1 and the
//   measurement sequencer is in its accumulate phase; samples offered at any
//   other time are dropped, and gaps in mon_valid simply stall accumulation.
module ring_lock_controller #(
    parameter int CODE_W        = 8,
    parameter int PWR_W         = 10,
    parameter int SETTLE_CYCLES = 16,
    parameter int AVG_SHIFT     = 2,
    parameter int LOSS_THRESH   = 512,
    parameter int LOSS_COUNT    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              mon_valid,
    input  logic [PWR_W-1:0]  mon_power,
    output logic [CODE_W-1:0] heater_code,
    output logic              code_update,
    output logic              locked,
    output logic [1:0]        state
);

    // Top-level controller states (also visible on the state port)
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SWEEP  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    // Measurement sub-sequence phases
    localparam logic [1:0] PH_SETTLE = 2'd0;
    localparam logic [1:0] PH_ACC    = 2'd1;
    localparam logic [1:0] PH_EVAL   = 2'd2;

    localparam int SUM_W  = PWR_W + AVG_SHIFT;
    localparam int NSAMP  = 1 << AVG_SHIFT;
    localparam int SET_W  = $clog2(SETTLE_CYCLES + 1);
    localparam int SMP_W  = AVG_SHIFT + 1;
    localparam int MISS_W = $clog2(LOSS_COUNT + 1);

    localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [SMP_W-1:0]  SMP_LAST    = SMP_W'(NSAMP - 1);
    localparam logic [MISS_W-1:0] MISS_LAST   = MISS_W'(LOSS_COUNT);
    localparam logic [CODE_W-1:0] CODE_MAX    = '1;

    logic [1:0]        state_q, state_d;
    logic [1:0]        phase_q, phase_d;
    logic [SET_W-1:0]  settle_q, settle_d;
    logic [SMP_W-1:0]  smp_q, smp_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic [PWR_W-1:0]  best_q, best_d;
    logic [CODE_W-1:0] best_code_q, best_code_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              upd_q, upd_d;
    logic [MISS_W-1:0] miss_q, miss_d;
    logic [MISS_W-1:0] miss_nxt;
`ifdef RING_LOCK_TRACK_EN
    logic              dir_q, dir_d;      // 1 = probe code+1, 0 = probe code-1
    logic              probe_q, probe_d;  // 1 = current measurement is the probe
    logic [PWR_W-1:0]  ref_q, ref_d;      // reference average at the held code
`endif

    logic [PWR_W-1:0]  avg;
    logic              eval;
    logic              over_thresh;

    assign avg         = sum_q[SUM_W-1:AVG_SHIFT];
    assign eval        = (phase_q == PH_EVAL);
    assign over_thresh = (32'(avg) > LOSS_THRESH);

    assign heater_code = code_q;
    assign code_update = upd_q;
    assign locked      = (state_q == ST_LOCKED);
    assign state       = state_q;

    // Next-state logic: measurement sequencer, controller FSM, enable override
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        settle_d    = settle_q;
        smp_d       = smp_q;
        sum_d       = sum_q;
        best_d      = best_q;
        best_code_d = best_code_q;
        code_d      = code_q;
        miss_d      = miss_q;
        miss_nxt    = '0;
`ifdef RING_LOCK_TRACK_EN
        dir_d       = dir_q;
        probe_d     = probe_q;
        ref_d       = ref_q;
`endif

        // Settle, then accumulate 2^AVG_SHIFT valid samples, then one
        // evaluation cycle after which a fresh measurement begins.
        case (phase_q)
            PH_SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    phase_d  = PH_ACC;
                    settle_d = '0;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            PH_ACC: begin
                if (mon_valid) begin
                    sum_d = sum_q + SUM_W'(mon_power);
                    if (smp_q == SMP_LAST) begin
                        phase_d = PH_EVAL;
                    end else begin
                        smp_d = smp_q + 1'b1;
                    end
                end
            end
            default: begin
                phase_d  = PH_SETTLE;
                settle_d = '0;
                smp_d    = '0;
                sum_d    = '0;
            end
        endcase

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d     = ST_SWEEP;
                    code_d      = '0;
                    best_d      = '1;
                    best_code_d = '0;
                    miss_d      = '0;
                end
            end
            ST_SWEEP: begin
                if (eval) begin
                    // Strict compare keeps the lower code on a tie
                    if (avg < best_q) begin
                        best_d      = avg;
                        best_code_d = code_q;
                    end
                    if (code_q == CODE_MAX) begin
                        code_d  = (avg < best_q) ? code_q : best_code_q;
                        state_d = ST_LOCKED;
                        miss_d  = '0;
`ifdef RING_LOCK_TRACK_EN
                        dir_d   = 1'b1;
                        probe_d = 1'b0;
`endif
                    end else begin
                        code_d = code_q + 1'b1;
                    end
                end
            end
            ST_LOCKED: begin
                if (eval) begin
                    miss_nxt = over_thresh ? (miss_q + 1'b1) : '0;
                    if (miss_nxt == MISS_LAST) begin
                        miss_d      = '0;
                        state_d     = ST_SWEEP;
                        code_d      = '0;
                        best_d      = '1;
                        best_code_d = '0;
`ifdef RING_LOCK_TRACK_EN
                        probe_d     = 1'b0;
`endif
                    end else begin
                        miss_d = miss_nxt;
`ifdef RING_LOCK_TRACK_EN
                        if (!probe_q) begin
                            // Reference done: step to the probe code unless
                            // that would leave the code range.
                            ref_d = avg;
                            if (dir_q ? (code_q == CODE_MAX) : (code_q == '0)) begin
                                dir_d = ~dir_q;
                            end else begin
                                code_d  = dir_q ? (code_q + 1'b1) : (code_q - 1'b1);
                                probe_d = 1'b1;
                            end
                        end else begin
                            // Probe done: keep it if deeper, else step back
                            // and try the other side next time.
                            probe_d = 1'b0;
                            if (!(avg < ref_q)) begin
                                code_d = dir_q ? (code_q - 1'b1) : (code_q + 1'b1);
                                dir_d  = ~dir_q;
                            end
                        end
`endif
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Disabling wins over everything: go idle, hold the code.
        if (!enable) begin
            state_d = ST_IDLE;
            code_d  = code_q;
            miss_d  = '0;
`ifdef RING_LOCK_TRACK_EN
            probe_d = 1'b0;
`endif
        end

        // No measurement runs while idle or disabled
        if (!enable || state_q == ST_IDLE) begin
            phase_d  = PH_SETTLE;
            settle_d = '0;
            smp_d    = '0;
            sum_d    = '0;
        end

        upd_d = (code_d != code_q);
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            phase_q     <= PH_SETTLE;
            settle_q    <= '0;
            smp_q       <= '0;
            sum_q       <= '0;
            best_q      <= '1;
            best_code_q <= '0;
            code_q      <= '0;
            upd_q       <= 1'b0;
            miss_q      <= '0;
`ifdef RING_LOCK_TRACK_EN
            dir_q       <= 1'b1;
            probe_q     <= 1'b0;
            ref_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            settle_q    <= settle_d;
            smp_q       <= smp_d;
            sum_q       <= sum_d;
            best_q      <= best_d;
            best_code_q <= best_code_d;
            code_q      <= code_d;
            upd_q       <= upd_d;
            miss_q      <= miss_d;
`ifdef RING_LOCK_TRACK_EN
            dir_q       <= dir_d;
            probe_q     <= probe_d;
            ref_q       <= ref_d;
`endif
        end
    end

endmodule

// File: tb/tb_ring_lock_controller.sv
// tb_ring_lock_controller
//   Directed bench for ring_lock_controller (default parameters). Every
//   code_update pulse is matched against an expected {state, heater_code}
//   queue filled by the stimulus process; timing and hold/abort/reset
//   behaviour are checked directly against hand-computed values.
`timescale 1ns/1ps
module tb_ring_lock_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       mon_valid = 1'b0;
    logic [9:0] mon_power;
    logic [7:0] heater_code;
    logic       code_update;
    logic       locked;
    logic [1:0] state;

    // stimulus model controls
    int  notch = 100;
    bit  high_mode = 1'b0;
    bit  flat_mode = 1'b0;
    bit  toggle_valid = 1'b0;
    bit  mon_skip = 1'b0;

    // scoreboard
    logic [9:0] exp_q[$];
    logic [9:0] mon_exp;
    int total = 0;
    int bad = 0;
    int n;

    ring_lock_controller dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .mon_valid   (mon_valid),
        .mon_power   (mon_power),
        .heater_code (heater_code),
        .code_update (code_update),
        .locked      (locked),
        .state       (state)
    );

    // ---------------- clock ----------------
    always #12.5 clk = ~clk;

    // ---------------- photodetector model ----------------
    function automatic logic [9:0] model_pwr(input logic [7:0] c, input int nt);
        int d;
        d = int'(c) - nt;
        if (d < 0) d = -d;
        return 10'(4 * d + 50);
    endfunction

    always_comb begin
        if (high_mode)      mon_power = 10'd1000;
        else if (flat_mode) mon_power = 10'd300;
        else                mon_power = model_pwr(heater_code, notch);
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (toggle_valid) mon_valid = ~mon_valid;
            else              mon_valid = 1'b1;
        end
    end

    // ---------------- checks ----------------
    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_sweep(input logic [7:0] lock_code);
        for (int c = 1; c < 256; c++) exp_q.push_back({2'd1, 8'(c)});
        if (lock_code != 8'hFF) exp_q.push_back({2'd2, lock_code});
    endtask

    // Call at the falling edge right after state became SWEEP; returns the
    // number of falling edges until locked is seen.
    task automatic wait_lock(input int budget, output int cnt);
        cnt = 0;
        while (!locked && cnt < budget) begin
            @(negedge clk);
            cnt++;
        end
        check("lock_reached", int'(locked), 1);
    endtask

    // monitor: every code_update pulse must match the head of the queue
    always @(negedge clk) begin
        if (rst_n && code_update && !mon_skip) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL code_update_unexpected: got state=%0d code=%0d, expected no pulse",
                         state, heater_code);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({state, heater_code} != mon_exp) begin
                    bad++;
                    $display("FAIL code_update_seq: got state=%0d code=%0d, expected state=%0d code=%0d",
                             state, heater_code, mon_exp[9:8], mon_exp[7:0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        // reset held with enable=1
        enable = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_heater_code", int'(heater_code), 0);
        check("reset_locked", int'(locked), 0);
        check("reset_state", int'(state), 0);
        check("reset_code_update", int'(code_update), 0);

        // full sweep toward notch at 100
        push_sweep(8'd100);
        rst_n = 1'b1;
        @(negedge clk);
        check("sweep_entry_state", int'(state), 1);
        check("sweep_entry_code", int'(heater_code), 0);
        wait_lock(6000, n);
        check("sweep_lock_cycles", n, 5376);
        check("sweep_lock_code", int'(heater_code), 100);
        check("sweep_lock_state", int'(state), 2);
        #1;
        check("sweep_queue_drained", exp_q.size(), 0);

        // loss of lock: 4 misses of 21 cycles each
        exp_q.push_back({2'd1, 8'd0});
        high_mode = 1'b1;
        n = 0;
        while (locked && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("loss_cycles", n, 84);
        check("loss_state", int'(state), 1);
        check("loss_code", int'(heater_code), 0);
        high_mode = 1'b0;
        push_sweep(8'd100);
        wait_lock(6000, n);
        check("relock_cycles", n, 5376);
        check("relock_code", int'(heater_code), 100);

        // notch moves to 103
        notch = 103;
`ifdef RING_LOCK_TRACK_EN
        mon_skip = 1'b1;
        repeat (40 * 21) @(negedge clk);
        check("track_near_103", int'(heater_code >= 8'd102 && heater_code <= 8'd104), 1);
        check("track_locked", int'(locked), 1);
        enable = 1'b0;
        @(negedge clk);
        mon_skip = 1'b0;
`else
        repeat (30 * 21) @(negedge clk);
        check("hold_code", int'(heater_code), 100);
        check("hold_locked", int'(locked), 1);
        enable = 1'b0;
        @(negedge clk);
        check("disable_code_held", int'(heater_code), 100);
`endif
        check("disable_state", int'(state), 0);
        check("disable_locked", int'(locked), 0);
        notch = 100;

        // abort mid-sweep at code 37
        exp_q.push_back({2'd1, 8'd0});
        for (int c = 1; c <= 37; c++) exp_q.push_back({2'd1, 8'(c)});
        enable = 1'b1;
        n = 0;
        while (heater_code != 8'd37 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("abort_reach_37", int'(heater_code), 37);
        enable = 1'b0;
        @(negedge clk);
        check("abort_state", int'(state), 0);
        check("abort_code_held", int'(heater_code), 37);
        check("abort_locked", int'(locked), 0);
        repeat (5) @(negedge clk);
        check("abort_code_still_held", int'(heater_code), 37);

        // re-enable: fresh sweep from 0
        exp_q.push_back({2'd1, 8'd0});
        push_sweep(8'd100);
        enable = 1'b1;
        @(negedge clk);
        check("reenable_state", int'(state), 1);
        check("reenable_code", int'(heater_code), 0);
        wait_lock(6000, n);
        check("reenable_lock_cycles", n, 5376);
        check("reenable_lock_code", int'(heater_code), 100);

        // tie and stall: flat power, mon_valid toggling
        enable = 1'b0;
        @(negedge clk);
        flat_mode = 1'b1;
        toggle_valid = 1'b1;
        exp_q.push_back({2'd1, 8'd0});
        push_sweep(8'd0);
        enable = 1'b1;
        @(negedge clk);
        check("tie_entry_state", int'(state), 1);
        wait_lock(8000, n);
        check("tie_lock_code", int'(heater_code), 0);
        check("tie_cycles_in_range", int'(n >= 256 * 24 && n <= 256 * 25), 1);
        flat_mode = 1'b0;
        toggle_valid = 1'b0;

        // asynchronous reset mid-operation
        repeat (50) @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midreset_code", int'(heater_code), 0);
        check("midreset_state", int'(state), 0);
        check("midreset_locked", int'(locked), 0);
        @(negedge clk);
        check("midreset_code_update", int'(code_update), 0);
        check("final_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
